kanagawa_sim_mailbox_to_valid: RTL



---
 rtl/kanagawa_sim_pkg.sv | 14 +
 rtl/kanagawa_sim_mailbox_writer.sv | 48 ++++
 rtl/kanagawa_sim_mailbox_to_valid.sv | 114 +++++++++++
 3 files changed

// File: rtl/kanagawa_sim_pkg.sv
// Shared definitions for the Kanagawa simulation mailbox sources/sinks:
// emitter state encoding and gap-counter width.
package kanagawa_sim_pkg;

  localparam int GAP_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2,
    S_STALL  = 2'd3
  } state_e;

endpackage

// File: rtl/kanagawa_sim_mailbox_writer.sv
// Item queue behind the valid emitter: bench-side put/try_put/num/clear
// plus a pop used by the emitter FSM.
interface kanagawa_sim_mailbox_writer #(
  parameter type T           = logic [7:0],
  parameter int  QUEUE_DEPTH = 0
) (
  input logic clk,
  input logic i_hold
);

  T            q[$];
  int unsigned count;

  function automatic bit full();
    return (QUEUE_DEPTH != 0) && (q.size() >= QUEUE_DEPTH);
  endfunction

  // Puts land between clock edges so the emitter sees them at the next posedge.
  task automatic put(input T item);
    while (full() || i_hold) @(negedge clk);
    q.push_back(item);
    count = q.size();
  endtask

  function automatic bit try_put(input T item);
    if (full() || i_hold) return 1'b0;
    q.push_back(item);
    count = q.size();
    return 1'b1;
  endfunction

  function automatic int num();
    return q.size();
  endfunction

  function automatic void clear();
    q.delete();
    count = 0;
  endfunction

  function automatic T pop();
    T v;
    v     = q.pop_front();
    count = q.size();
    return v;
  endfunction

endinterface

// File: rtl/kanagawa_sim_mailbox_to_valid.sv
// Simulation source: drains a typed mailbox onto a registered valid/data pair,
// paced by a programmable inter-item gap and almost_full_in backpressure.
module kanagawa_sim_mailbox_to_valid
  import kanagawa_sim_pkg::*;
#(
  parameter type T              = logic [7:0],
  parameter int  QUEUE_DEPTH    = 0,
  parameter int  DEFAULT_GAP    = 0,
  parameter bit  CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 almost_full_in,
  output logic                 valid_out,
  output logic [$bits(T)-1:0]  data_out,
  output logic                 busy,
  output logic [31:0]          sent_count
);

  state_e             r_state;
  logic               r_valid;
  logic [$bits(T)-1:0] r_data;
  logic [31:0]        r_sent_count;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   r_gap_cycles = GAP_W'(DEFAULT_GAP);
  logic               w_hold;
  logic               w_has_item;
  logic               w_emit;

  assign w_hold = !rst_n && CLEAR_ON_RESET;

  kanagawa_sim_mailbox_writer #(
    .T           (T),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_mbox (
    .clk    (clk),
    .i_hold (w_hold)
  );

  assign w_has_item = (u_mbox.count != 0);
  assign w_emit     = w_has_item && !almost_full_in && (r_gap_cnt == '0) &&
                      (r_state != S_GAP);

  // The gap counter runs down in every state so a clear() mid-gap cannot shorten it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_sent_count <= '0;
      r_gap_cnt    <= '0;
      if (CLEAR_ON_RESET) u_mbox.clear();
    end else begin
      r_valid <= 1'b0;
      if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
      if (w_emit) begin
        r_data       <= u_mbox.pop();
        r_valid      <= 1'b1;
        r_sent_count <= r_sent_count + 32'd1;
        r_gap_cnt    <= r_gap_cycles;
        if (r_gap_cycles != '0)    r_state <= S_GAP;
        else if (!w_has_item)      r_state <= S_IDLE;
        else if (u_mbox.count == 0) r_state <= S_IDLE;
        else                       r_state <= S_ACTIVE;
      end else begin
        unique case (r_state)
          S_IDLE, S_ACTIVE: begin
            if (!w_has_item)            r_state <= S_IDLE;
            else if (r_gap_cnt == '0)   r_state <= S_STALL;
            else                        r_state <= S_ACTIVE;
          end
          S_GAP: begin
            if (!w_has_item)            r_state <= S_IDLE;
            else if (r_gap_cnt <= 1)    r_state <= S_ACTIVE;
          end
          S_STALL: begin
            if (!w_has_item)            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign valid_out  = r_valid;
  assign data_out   = r_data;
  assign sent_count = r_sent_count;
  assign busy       = w_has_item || r_valid;

  task automatic put(input T item);
    u_mbox.put(item);
  endtask

  function automatic bit try_put(input T item);
    return u_mbox.try_put(item);
  endfunction

  function automatic int num();
    return u_mbox.num();
  endfunction

  function automatic void clear();
    u_mbox.clear();
  endfunction

  function automatic void set_gap(input int n);
    r_gap_cycles = GAP_W'(n);
  endfunction

  task automatic wait_idle();
    @(posedge clk);
    while (busy) @(posedge clk);
  endtask

endmodule
